seq_detect_1011: RTL and testbench

Serial pattern detector that sits directly downstream of the D flip-flop stage and consumes its registered Q bit stream one bit per clock. It runs a 5-state Moore FSM that recognises the bit pattern 1011 (oldest bit first). On each match it emits a one-cycle pulse, keeps a saturating match count, and exposes the last four sampled bits for debug.

---
 rtl/seq_detect_1011_if.sv | 35 +++
 rtl/seq_detect_1011.sv | 85 ++++++++
 tb/tb_seq_detect_1011.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_1011_if.sv
// Bundles the detector's sample inputs and registered status outputs.
// The master modport drives the bit stream; the slave modport is the detector.
interface seq_detect_1011_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic             bit_in;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [3:0]       shift_q;
  logic [2:0]       state_q;

  modport master (
    output en,
    output bit_in,
    output cnt_clr,
    input  match,
    input  match_cnt,
    input  shift_q,
    input  state_q
  );

  modport slave (
    input  en,
    input  bit_in,
    input  cnt_clr,
    output match,
    output match_cnt,
    output shift_q,
    output state_q
  );

endinterface

// File: rtl/seq_detect_1011.sv
// Moore FSM detecting serial pattern 1011 with match pulse, saturating count and debug taps.
// Define SEQ_OVERLAP_EN for overlapping detection (S4 on input 0 goes to S2 instead of S0).
module seq_detect_1011 #(
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_1011_if.slave  bus
);

  if (CNT_W < 2 || CNT_W > 16) begin : gen_cnt_w_check
    $error("CNT_W must be in 2..16");
  end

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           fsm_q, fsm_d;
  logic [3:0]       shreg_q, shreg_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic; illegal encodings recover to S0 even while disabled.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S0: if (bus.en) fsm_d = bus.bit_in ? S1 : S0;
      S1: if (bus.en) fsm_d = bus.bit_in ? S1 : S2;
      S2: if (bus.en) fsm_d = bus.bit_in ? S3 : S0;
      S3: if (bus.en) fsm_d = bus.bit_in ? S4 : S2;
`ifdef SEQ_OVERLAP_EN
      S4: if (bus.en) fsm_d = bus.bit_in ? S1 : S2;
`else
      S4: if (bus.en) fsm_d = bus.bit_in ? S1 : S0;
`endif
      default: fsm_d = S0;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    if (bus.en) begin
      shreg_d = {shreg_q[2:0], bus.bit_in};
    end
  end

  assign match_d = bus.en && (fsm_d == S4);

  // A clear coinciding with a match loads 1 so that match is not lost.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S0;
      shreg_q <= 4'b0000;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      shreg_q <= shreg_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.shift_q   = shreg_q;
  assign bus.state_q   = fsm_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Self-checking bench for seq_detect_1011: directed scenarios plus random stream
// against a pattern-history reference model; runs CNT_W=8 and CNT_W=2 instances in parallel.
module tb_seq_detect_1011;

  logic clk;
  logic rst_n;

  seq_detect_1011_if #(.CNT_W(8)) bus8 ();
  seq_detect_1011_if #(.CNT_W(2)) bus2 ();

  seq_detect_1011 #(.CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  seq_detect_1011 #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: recent consumed bits, state = longest suffix that prefixes 1011.
  bit          pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          hist [$];
  int unsigned m_state;
  logic        m_match;
  int unsigned m_cnt8, m_cnt2;
  logic [3:0]  m_shift;
  int          n_matches;

  function automatic int unsigned prefix_len();
    int n;
    bit ok;
    n = hist.size();
    for (int k = 4; k >= 1; k--) begin
      if (n >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          if (hist[n-k+i] != pat[i]) ok = 1'b0;
        end
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic int unsigned cnt_next(input int unsigned cnt, input int unsigned maxv,
                                           input logic clr, input logic mt);
    if (clr) return mt ? 1 : 0;
    if (mt && cnt < maxv) return cnt + 1;
    return cnt;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic b, input logic c);
    if (!r) begin
      hist.delete();
      m_state = 0;
      m_match = 1'b0;
      m_cnt8  = 0;
      m_cnt2  = 0;
      m_shift = 4'b0000;
    end else begin
      if (e) begin
        hist.push_back(b);
        if (hist.size() > 4) void'(hist.pop_front());
        m_shift = {m_shift[2:0], b};
        m_state = prefix_len();
        m_match = (m_state == 4);
`ifndef SEQ_OVERLAP_EN
        // Non-overlapping: a completed pattern contributes nothing to the next one.
        if (m_match) hist.delete();
`endif
      end else begin
        m_match = 1'b0;
      end
      if (m_match) n_matches++;
      m_cnt8 = cnt_next(m_cnt8, 255, c, m_match);
      m_cnt2 = cnt_next(m_cnt2, 3, c, m_match);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".state"}, 32'(bus8.state_q), m_state);
    check_eq({tag, ".match"}, 32'(bus8.match), 32'(m_match));
    check_eq({tag, ".shift"}, 32'(bus8.shift_q), 32'(m_shift));
    check_eq({tag, ".cnt8"}, 32'(bus8.match_cnt), m_cnt8);
    check_eq({tag, ".cnt2"}, 32'(bus2.match_cnt), m_cnt2);
    check_eq({tag, ".match2"}, 32'(bus2.match), 32'(m_match));
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic b,
                      input logic c);
    @(negedge clk);
    rst_n        = r;
    bus8.en      = e;
    bus8.bit_in  = b;
    bus8.cnt_clr = c;
    bus2.en      = e;
    bus2.bit_in  = b;
    bus2.cnt_clr = c;
    @(posedge clk);
    model_update(r, e, b, c);
    #1;
    compare_all(tag);
  endtask

  task automatic send_bits(input string tag, input logic [3:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, 1'b1, bits[i], 1'b0);
  endtask

  initial begin
    logic [7:0] seq7;
    logic       e, c, r;
    rst_n        = 1'b0;
    bus8.en      = 1'b0;
    bus8.bit_in  = 1'b0;
    bus8.cnt_clr = 1'b0;
    bus2.en      = 1'b0;
    bus2.bit_in  = 1'b0;
    bus2.cnt_clr = 1'b0;
    hist.delete();
    m_state   = 0;
    m_match   = 1'b0;
    m_cnt8    = 0;
    m_cnt2    = 0;
    m_shift   = 4'b0000;
    n_matches = 0;

    // Reset with toggling data
    step("rst0", 1'b0, 1'b1, 1'b1, 1'b0);
    step("rst1", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("rst.state_q", 32'(bus8.state_q), 0);
    check_eq("rst.shift_q", 32'(bus8.shift_q), 0);
    check_eq("rst.match_cnt", 32'(bus8.match_cnt), 0);

    // Basic match
    send_bits("basic", 4'b1011, 4);
    check_eq("basic.match", 32'(bus8.match), 1);
    check_eq("basic.cnt", 32'(bus8.match_cnt), 1);
    check_eq("basic.shift", 32'(bus8.shift_q), 32'h0000_000b);
    step("basic_after", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("basic.pulse_width", 32'(bus8.match), 0);

    // Overlap: 1011011
    step("ovl_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    seq7 = 8'b0101_1011;
    for (int i = 6; i >= 0; i--) step("ovl", 1'b1, 1'b1, seq7[i], 1'b0);
`ifdef SEQ_OVERLAP_EN
    check_eq("ovl.cnt", 32'(bus8.match_cnt), 2);
`else
    check_eq("ovl.cnt", 32'(bus8.match_cnt), 1);
`endif

    // Enable gap while in S3
    step("gap_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits("gap_pre", 4'b0101, 3);
    for (int i = 0; i < 3; i++) begin
      step("gap", 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("gap.state_hold", 32'(bus8.state_q), 3);
      check_eq("gap.match_low", 32'(bus8.match), 0);
    end
    step("gap_end", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("gap.match", 32'(bus8.match), 1);

    // Saturation on the 2-bit counter, then clear coinciding with a match
    step("sat_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_bits("sat", 4'b1011, 4);
    check_eq("sat.cnt2", 32'(bus2.match_cnt), 3);
    check_eq("sat.cnt8", 32'(bus8.match_cnt), 5);
    send_bits("clr_pre", 4'b0101, 3);
    step("clr_match", 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("clr.cnt2", 32'(bus2.match_cnt), 1);
    check_eq("clr.cnt8", 32'(bus8.match_cnt), 1);

    // Reset mid-pattern
    send_bits("mid_pre", 4'b0101, 3);
    step("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0);
    step("mid_post", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("mid.state_q", 32'(bus8.state_q), 1);
    check_eq("mid.match", 32'(bus8.match), 0);

    // Random stream
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 99) < 85);
      c = e && ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) != 0);
      step("rand", r, e, 1'($urandom), c);
    end
    check_eq("rand.some_matches", 32'(n_matches > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
